// File: rtl/readout_pkg.sv
// Shared field widths, scan states and output word packing for the region readout scanner.
package readout_pkg;

    localparam int REGION_W = 3;
    localparam int ADDR_W   = 5;
    localparam int COUNT_W  = 24;
    localparam int WORD_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        DRAIN,
        DONE
    } scan_state_e;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [REGION_W-1:0] region,
        input logic [ADDR_W-1:0]   addr,
        input logic [COUNT_W-1:0]  count
    );
        return {region, addr, count};
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// Show-ahead synchronous FIFO: o_data is the head entry whenever o_empty is low.
module readout_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr;
    logic [PtrW-1:0]  r_rd;
    logic [CntW-1:0]  r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees the slot in the same edge, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_full  = (r_cnt == CntW'(Depth));
    assign o_empty = (r_cnt == '0);
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PtrW'(1);
            end
            if (w_do_pop) r_rd <= r_rd + PtrW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/region_readout_scanner.sv
// Sweeps every result address of every region through the shared read port and
// streams tagged counts out through a small show-ahead FIFO.
module region_readout_scanner
    import readout_pkg::*;
#(
    parameter int NumRegion   = 4,
    parameter int NumOsc      = 10,
    parameter int ReadLatency = 1,
    parameter int FifoDepth   = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         Start_i,
    output logic [ADDR_W-1:0]            Addr_o,
    input  logic [NumRegion*COUNT_W-1:0] Data_i,
    output logic                         Busy_o,
    output logic                         Done_o,
    output logic [WORD_W-1:0]            Word_o,
    output logic                         Valid_o,
    input  logic                         Ready_i
);

    localparam int                  WaitW      = 2;
    localparam logic [ADDR_W-1:0]   LastAddr   = ADDR_W'(NumOsc - 1);
    localparam logic [REGION_W-1:0] LastRegion = REGION_W'(NumRegion - 1);

    scan_state_e         r_state;
    logic [REGION_W-1:0] r_region;
    logic [ADDR_W-1:0]   r_addr;
    logic [WaitW-1:0]    r_wait;
    logic                r_busy;
    logic                r_done;

    logic [COUNT_W-1:0]  w_count;
    logic [WORD_W-1:0]   w_word;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_can_push;
    logic                w_push;

    assign Addr_o  = r_addr;
    assign Busy_o  = r_busy;
    assign Done_o  = r_done;
    assign Valid_o = !w_empty;

    always_comb begin
        w_count = '0;
        for (int r = 0; r < NumRegion; r++) begin
            if (r_region == REGION_W'(r)) w_count = Data_i[r*COUNT_W +: COUNT_W];
        end
    end

    assign w_word = pack_word(r_region, r_addr, w_count);

    // Full only blocks the capture when the consumer is not draining the head
    // in the same cycle.
    assign w_pop      = !w_empty && Ready_i;
    assign w_can_push = !w_full || Ready_i;
    assign w_push     = (r_state == CAPTURE) && w_can_push;

    readout_fifo #(
        .Width (WORD_W),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_data  (Word_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_region <= '0;
            r_addr   <= '0;
            r_wait   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start_i) begin
                        r_region <= '0;
                        r_addr   <= '0;
                        r_wait   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= READ;
                    end
                end
                READ: begin
                    r_wait <= r_wait + WaitW'(1);
                    if (r_wait == WaitW'(ReadLatency - 1)) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    // Address stays put while stalled so the re-sampled data matches.
                    if (w_can_push) begin
                        r_wait <= '0;
                        if (r_addr == LastAddr) begin
                            if (r_region == LastRegion) begin
                                r_state <= DRAIN;
                            end else begin
                                r_addr   <= '0;
                                r_region <= r_region + REGION_W'(1);
                                r_state  <= READ;
                            end
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= READ;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_region_readout_scanner.sv
// Randomized scoreboard bench for region_readout_scanner with a latency-accurate SRAM model.
module tb_region_readout_scanner;

    localparam int NR  = 2;
    localparam int NO  = 10;
    localparam int RL  = 1;
    localparam int FD  = 4;
    localparam int RL1 = 3;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic              rstn;
    logic              start;
    logic              ready;
    logic [4:0]        addr;
    logic [NR*24-1:0]  data;
    logic              busy;
    logic              done;
    logic [31:0]       word;
    logic              valid;

    logic              start1;
    logic [4:0]        addr1;
    logic [23:0]       data1;
    logic              busy1;
    logic              done1;
    logic [31:0]       word1;
    logic              valid1;
    logic              ready1;

    region_readout_scanner #(
        .NumRegion(NR), .NumOsc(NO), .ReadLatency(RL), .FifoDepth(FD)
    ) u_dut (
        .clk(clk), .rstn(rstn), .Start_i(start), .Addr_o(addr), .Data_i(data),
        .Busy_o(busy), .Done_o(done), .Word_o(word), .Valid_o(valid), .Ready_i(ready)
    );

    region_readout_scanner #(
        .NumRegion(1), .NumOsc(1), .ReadLatency(RL1), .FifoDepth(2)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .Start_i(start1), .Addr_o(addr1), .Data_i(data1),
        .Busy_o(busy1), .Done_o(done1), .Word_o(word1), .Valid_o(valid1), .Ready_i(ready1)
    );

    // SRAM model: contents per region, read data lags the address by RL cycles.
    logic [23:0] mem [NR][32];
    logic [4:0]  apipe [RL];

    initial for (int i = 0; i < RL; i++) apipe[i] = '0;

    always @(posedge clk) begin
        apipe[0] <= addr;
        for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
    end

    always_comb begin
        data = '0;
        for (int r = 0; r < NR; r++) data[r*24 +: 24] = mem[r][apipe[RL-1]];
    end

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] exp_q[$];
    int cyc = 0;
    int hs_cnt = 0;
    int first_hs = 0;
    int last_hs = 0;
    int done_cnt = 0;
    int done_at = 0;
    logic toggle_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_word(input int r, input int a, input logic [23:0] cnt);
        return (32'(r) << 29) | (32'(a) << 24) | 32'(cnt);
    endfunction

    // Monitor: scores every handshake and checks the head holds while stalled.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_word;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn) begin
                if (prev_stall) begin
                    check("stall_word", word, prev_word);
                    check("stall_valid", 32'(valid), 32'd1);
                end
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_word: got %h want none", word);
                    end else begin
                        check("word", word, exp_q.pop_front());
                    end
                    hs_cnt++;
                    if (hs_cnt == 1) first_hs = cyc;
                    last_hs = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_at = cyc;
                end
                prev_stall = valid && !ready;
                prev_word  = word;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_en) ready = ~ready;
    end

    task automatic fill_random();
        for (int r = 0; r < NR; r++)
            for (int a = 0; a < 32; a++)
                mem[r][a] = (a < NO) ? 24'($urandom) : 24'd0;
    endtask

    task automatic start_scan();
        for (int r = 0; r < NR; r++)
            for (int a = 0; a < NO; a++)
                exp_q.push_back(model_word(r, a, mem[r][a]));
        hs_cnt   = 0;
        done_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int k;
        k = 0;
        while (hs_cnt < n && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (hs_cnt < n) begin
            n_chk++;
            $display("FAIL wait_hs_timeout: got %0d want %0d", hs_cnt, n);
        end
    endtask

    task automatic finish_scan(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (busy && k < 3000);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_hs"}, 32'(hs_cnt), 32'(NR*NO));
        check({name, "_dones"}, 32'(done_cnt), 32'd1);
        check({name, "_done_gap"}, 32'(done_at - last_hs), 32'd2);
        check({name, "_busy_drop"}, 32'(cyc - done_at), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rstn   = 1'b0;
        start  = 1'b0;
        ready  = 1'b1;
        start1 = 1'b0;
        ready1 = 1'b1;
        data1  = 24'($urandom);
        for (int r = 0; r < NR; r++)
            for (int a = 0; a < 32; a++)
                mem[r][a] = (a < NO) ? 24'(r*256 + a) : 24'd0;

        #13;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_word", word, 32'd0);
        #20 rstn = 1'b1;

        // Free-running consumer: latency, throughput, completion timing.
        start_scan();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("lat_valid", 32'(valid), (k >= 2) ? 32'd1 : 32'd0);
            check("lat_busy", 32'(busy), 32'd1);
        end
        check("first_word_head", word, 32'h0000_0000);
        finish_scan("plain");
        check("throughput", 32'(last_hs - first_hs), 32'(2*(NR*NO-1)));

        // Long backpressure: scanner must park on address 4 with the FIFO full.
        fill_random();
        ready = 1'b0;
        start_scan();
        repeat (20) @(posedge clk);
        #1;
        check("bp_addr", 32'(addr), 32'd4);
        check("bp_valid", 32'(valid), 32'd1);
        check("bp_busy", 32'(busy), 32'd1);
        ready = 1'b1;
        finish_scan("bp");

        // Fill, then alternate ready so pushes land on a full FIFO being popped.
        fill_random();
        ready = 1'b0;
        start_scan();
        repeat (12) @(posedge clk);
        toggle_en = 1'b1;
        finish_scan("toggle");
        toggle_en = 1'b0;
        @(posedge clk);
        #2 ready = 1'b1;

        // Start while busy is dropped.
        fill_random();
        start_scan();
        wait_hs(5);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_scan("restart");
        repeat (4) @(negedge clk);
        check("restart_idle", 32'(busy), 32'd0);

        // Reset mid-scan flushes everything; a fresh scan starts at address 0.
        fill_random();
        start_scan();
        wait_hs(7);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        done_cnt = 0;
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_dones", 32'(done_cnt), 32'd0);
        fill_random();
        start_scan();
        finish_scan("after_rst");

        // Single-entry instance with three-cycle read latency.
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            check("l3_valid", 32'(valid1), (k == 4) ? 32'd1 : 32'd0);
            check("l3_done", 32'(done1), (k == 6) ? 32'd1 : 32'd0);
            check("l3_busy", 32'(busy1), (k <= 6) ? 32'd1 : 32'd0);
            if (k == 4) check("l3_word", word1, model_word(0, 0, data1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
